// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the push-button debounce controller.
//   KEY_DATA_W      : width of the register slave data bus
//   KEY_ADDR_*      : word addresses of the register map
//   key_idle_level  : raw pin level of a released button for a given polarity
// ---------------------------------------------------------------------------
package key_pkg;

   localparam int KEY_DATA_W = 32;

   localparam logic [1:0] KEY_ADDR_STATE = 2'd0;
   localparam logic [1:0] KEY_ADDR_EVENT = 2'd1;
   localparam logic [1:0] KEY_ADDR_IRQEN = 2'd2;

   // A pull-up button idles high, a pull-down button idles low.
   function automatic logic key_idle_level(input int active_low);
      return (active_low != 0);
   endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// ---------------------------------------------------------------------------
// key_debounce_bit
// One push-button channel: 2-FF synchroniser, persistence counter, stable
// state and registered press/release pulses.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   key_in       : raw asynchronous pin
//   key_state    : debounced level, 1 = pressed
//   key_press    : one-cycle pulse the cycle after key_state rises
//   key_release  : one-cycle pulse the cycle after key_state falls
// ---------------------------------------------------------------------------
module key_debounce_bit
   import key_pkg::*;
#(
   parameter int DB_CYCLES      = 500000,
   parameter int KEY_ACTIVE_LOW = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_state,
   output logic key_press,
   output logic key_release
);

   localparam int              CNT_W      = $clog2(DB_CYCLES);
   localparam logic            IDLE_LEVEL = key_idle_level(KEY_ACTIVE_LOW);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DB_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             sampled;
   logic             state_prev;
   logic [CNT_W-1:0] count;

   // Two-stage synchroniser. Both stages reset to the released pin level so
   // the debouncer sees an idle key straight out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= IDLE_LEVEL;
         sync2 <= IDLE_LEVEL;
      end else begin
         sync1 <= key_in;
         sync2 <= sync1;
      end
   end

   // XOR with the idle level turns the pin into "1 = pressed" for either polarity.
   assign sampled = sync2 ^ IDLE_LEVEL;

   // Persistence counter: any sample agreeing with the stable state restarts
   // the count, so only a run of DB_CYCLES disagreeing samples flips the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         key_state <= 1'b0;
      end else if (sampled == key_state) begin
         count <= '0;
      end else if (count == CNT_LAST) begin
         key_state <= ~key_state;
         count     <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   // Edge pulses come from comparing the stable state with its previous value;
   // both reset to 0 so leaving reset never looks like an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_prev  <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         state_prev  <= key_state;
         key_press   <= key_state & ~state_prev;
         key_release <= ~key_state & state_prev;
      end
   end

endmodule

// File: rtl/key_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// key_debounce_ctrl
// NKEY debounced push-buttons with a small register slave and a level irq.
// Ports:
//   clk, rst                  : system clock, synchronous active-high reset
//   key_in[NKEY]              : raw button pins
//   key_state/press/release   : debounced level and one-cycle edge pulses
//   reg_sel, reg_we, reg_addr : register access strobe, write flag, word address
//   reg_wdata, reg_rdata      : write data, registered read data
//   irq                       : OR of pending enabled press events
// Register map: 0 key_state (RO), 1 event (W1C), 2 irq_en (RW), 3 reads 0.
// ---------------------------------------------------------------------------
module key_debounce_ctrl
   import key_pkg::*;
#(
   parameter int NKEY           = 4,
   parameter int DB_CYCLES      = 500000,
   parameter int KEY_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NKEY-1:0]       key_in,
   output logic [NKEY-1:0]       key_state,
   output logic [NKEY-1:0]       key_press,
   output logic [NKEY-1:0]       key_release,
   input  logic                  reg_sel,
   input  logic                  reg_we,
   input  logic [1:0]            reg_addr,
   input  logic [KEY_DATA_W-1:0] reg_wdata,
   output logic [KEY_DATA_W-1:0] reg_rdata,
   output logic                  irq
);

   logic [NKEY-1:0]       event_q;
   logic [NKEY-1:0]       irq_en_q;
   logic [NKEY-1:0]       event_clr;
   logic                  rd_en;
   logic                  wr_irq_en;
   logic [KEY_DATA_W-1:0] rdata_next;
   logic                  unused_wdata;

   // One independent debounce channel per key.
   for (genvar i = 0; i < NKEY; i++) begin : g_key
      key_debounce_bit #(
         .DB_CYCLES      (DB_CYCLES),
         .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
      ) u_bit (
         .clk         (clk),
         .rst         (rst),
         .key_in      (key_in[i]),
         .key_state   (key_state[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i])
      );
   end

   // Write-data bits above NKEY have no storage behind them.
   assign unused_wdata = ^reg_wdata;

   // Access decode: W1C mask for the event register and irq_en write enable.
   always_comb begin
      rd_en     = reg_sel && !reg_we;
      wr_irq_en = reg_sel && reg_we && (reg_addr == KEY_ADDR_IRQEN);
      event_clr = '0;
      if (reg_sel && reg_we && (reg_addr == KEY_ADDR_EVENT)) begin
         event_clr = reg_wdata[NKEY-1:0];
      end
   end

   // Read mux; unused upper bits and the spare address return zero.
   always_comb begin
      rdata_next = '0;
      case (reg_addr)
         KEY_ADDR_STATE: rdata_next[NKEY-1:0] = key_state;
         KEY_ADDR_EVENT: rdata_next[NKEY-1:0] = event_q;
         KEY_ADDR_IRQEN: rdata_next[NKEY-1:0] = irq_en_q;
         default:        rdata_next = '0;
      endcase
   end

   // Register file and interrupt. The press pulse is OR-ed in after the clear
   // mask so a press landing on the same cycle as a W1C keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         event_q   <= '0;
         irq_en_q  <= '0;
         reg_rdata <= '0;
         irq       <= 1'b0;
      end else begin
         event_q <= (event_q & ~event_clr) | key_press;
         if (wr_irq_en) begin
            irq_en_q <= reg_wdata[NKEY-1:0];
         end
         if (rd_en) begin
            reg_rdata <= rdata_next;
         end
         irq <= |(event_q & irq_en_q);
      end
   end

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_ctrl
// Self-checking bench for key_debounce_ctrl with NKEY=4, DB_CYCLES=8,
// active-low keys. A behavioural model tracks each key's recent pin history
// and the register state; every cycle the DUT outputs are compared with it,
// alongside fixed expectations for the hand-written scenarios.
// ---------------------------------------------------------------------------
module tb_key_debounce_ctrl;

   localparam int NKEY = 4;
   localparam int DB   = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [NKEY-1:0] keyIn;
   logic            regSel;
   logic            regWe;
   logic [1:0]      regAddr;
   logic [31:0]     regWdata;
   logic [NKEY-1:0] key_state;
   logic [NKEY-1:0] key_press;
   logic [NKEY-1:0] key_release;
   logic [31:0]     reg_rdata;
   logic            irq;

   int total = 0;
   int bad   = 0;

   // Reference model state (values as seen after the latest clock edge)
   logic [DB+1:0]   mHist [NKEY];
   logic [NKEY-1:0] mState    = '0;
   logic [NKEY-1:0] mStateOld = '0;
   logic [NKEY-1:0] mPress    = '0;
   logic [NKEY-1:0] mRelease  = '0;
   logic [NKEY-1:0] mEvent    = '0;
   logic [NKEY-1:0] mEn       = '0;
   logic            mIrq      = 1'b0;
   logic [31:0]     mRdata    = '0;

   typedef struct {
      logic        sel;
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] expRdata;
   } vec_t;

   vec_t vecs [15];

   key_debounce_ctrl #(
      .NKEY           (NKEY),
      .DB_CYCLES      (DB),
      .KEY_ACTIVE_LOW (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_in      (keyIn),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .reg_sel     (regSel),
      .reg_we      (regWe),
      .reg_addr    (regAddr),
      .reg_wdata   (regWdata),
      .reg_rdata   (reg_rdata),
      .irq         (irq)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [NKEY-1:0] k, input logic s, input logic w,
                                input logic [1:0] a, input logic [31:0] d);
      keyIn    = k;
      regSel   = s;
      regWe    = w;
      regAddr  = a;
      regWdata = d;
   endtask

   // Advance one clock: update the model from the inputs present at the edge,
   // then compare every DUT output 1 ns after the edge.
   task automatic tick();
      logic            rstNow;
      logic            selNow;
      logic            weNow;
      logic [1:0]      addrNow;
      logic [31:0]     wdataNow;
      logic [NKEY-1:0] pinPressed;
      logic [NKEY-1:0] clrMask;
      logic [NKEY-1:0] flipMask;
      logic [31:0]     readVal;
      rstNow     = rst;
      selNow     = regSel;
      weNow      = regWe;
      addrNow    = regAddr;
      wdataNow   = regWdata;
      pinPressed = ~keyIn;
      @(posedge clk);
      if (rstNow) begin
         mState    = '0;
         mStateOld = '0;
         mPress    = '0;
         mRelease  = '0;
         mEvent    = '0;
         mEn       = '0;
         mIrq      = 1'b0;
         mRdata    = '0;
         for (int k = 0; k < NKEY; k++) mHist[k] = '0;
      end else begin
         readVal = '0;
         case (addrNow)
            2'd0:    readVal[NKEY-1:0] = mState;
            2'd1:    readVal[NKEY-1:0] = mEvent;
            2'd2:    readVal[NKEY-1:0] = mEn;
            default: readVal = '0;
         endcase
         if (selNow && !weNow) mRdata = readVal;
         clrMask = (selNow && weNow && addrNow == 2'd1) ? wdataNow[NKEY-1:0] : '0;
         mIrq    = |(mEvent & mEn);
         mEvent  = (mEvent & ~clrMask) | mPress;
         if (selNow && weNow && addrNow == 2'd2) mEn = wdataNow[NKEY-1:0];
         // Pulses appear one cycle after the stable state changed.
         mPress   = mState & ~mStateOld;
         mRelease = ~mState & mStateOld;
         // A key flips once the DB synchronised samples (pins 2..DB+1 edges
         // old) all disagree with its current stable state.
         flipMask = '0;
         for (int k = 0; k < NKEY; k++) begin
            mHist[k] = {mHist[k][DB:0], pinPressed[k]};
            if (mState[k] ? (mHist[k][DB+1:2] == '0) : (mHist[k][DB+1:2] == '1)) flipMask[k] = 1'b1;
         end
         mStateOld = mState;
         mState    = mState ^ flipMask;
      end
      #1;
      checkOutput("model_key_state", key_state, mState);
      checkOutput("model_key_press", key_press, mPress);
      checkOutput("model_key_release", key_release, mRelease);
      checkOutput("model_irq", irq, mIrq);
      checkOutput("model_rdata", reg_rdata, mRdata);
   endtask

   task automatic regWrite(input logic [1:0] a, input logic [31:0] d);
      applyStimulus(keyIn, 1'b1, 1'b1, a, d);
      tick();
      applyStimulus(keyIn, 1'b0, 1'b0, 2'd0, 32'h0);
   endtask

   task automatic regRead(input logic [1:0] a, input logic [31:0] exp, input string name);
      applyStimulus(keyIn, 1'b1, 1'b0, a, 32'h0);
      tick();
      checkOutput(name, reg_rdata, exp);
      applyStimulus(keyIn, 1'b0, 1'b0, 2'd0, 32'h0);
   endtask

   initial begin
      logic            seen;
      int              n;
      int              hold [NKEY];
      logic [NKEY-1:0] rk;
      int              op;

      for (int k = 0; k < NKEY; k++) mHist[k] = '0;

      // Register access vectors applied from reset with all keys idle
      vecs[0]  = '{1'b1, 1'b1, 2'd2, 32'hFFFF_FFFA, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'hA};
      vecs[2]  = '{1'b1, 1'b1, 2'd0, 32'hF,         32'hA};
      vecs[3]  = '{1'b1, 1'b0, 2'd0, 32'h0,         32'h0};
      vecs[4]  = '{1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
      vecs[5]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'hA};
      vecs[6]  = '{1'b1, 1'b0, 2'd3, 32'h0,         32'h0};
      vecs[7]  = '{1'b1, 1'b1, 2'd2, 32'h5,         32'h0};
      vecs[8]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h5};
      vecs[9]  = '{1'b0, 1'b0, 2'd1, 32'h0,         32'h5};
      vecs[10] = '{1'b0, 1'b1, 2'd2, 32'hF,         32'h5};
      vecs[11] = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h5};
      vecs[12] = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h5};
      vecs[13] = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h0};
      vecs[14] = '{1'b1, 1'b0, 2'd1, 32'h0,         32'h0};

      // Idle after reset
      applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'h0);
      rst = 1'b1;
      repeat (3) tick();
      checkOutput("reset_outputs", {key_state, key_press, key_release}, 32'h0);
      checkOutput("reset_irq", irq, 32'h0);
      checkOutput("reset_rdata", reg_rdata, 32'h0);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (50) begin
         tick();
         seen = seen | (|key_press) | (|key_release) | irq;
      end
      checkOutput("idle_state", key_state, 32'h0);
      checkOutput("idle_no_pulse", seen, 32'h0);
      regRead(2'd1, 32'h0, "idle_event");

      // Register map table
      foreach (vecs[i]) begin
         applyStimulus(4'hF, vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         tick();
         checkOutput($sformatf("vec%0d_rdata", i), reg_rdata, vecs[i].expRdata);
      end
      applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'h0);

      // Bounce rejection on key 0
      seen = 1'b0;
      repeat (4) begin
         applyStimulus(4'hE, 1'b0, 1'b0, 2'd0, 32'h0);
         repeat (5) begin tick(); seen = seen | key_press[0]; end
         applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'h0);
         repeat (5) begin tick(); seen = seen | key_press[0]; end
      end
      repeat (5) begin tick(); seen = seen | key_press[0]; end
      checkOutput("bounce_state", key_state[0], 32'h0);
      checkOutput("bounce_no_press", seen, 32'h0);

      // Clean press and release on key 0
      applyStimulus(4'hE, 1'b0, 1'b0, 2'd0, 32'h0);
      repeat (9) tick();
      checkOutput("press_latency_9", key_state[0], 32'h0);
      tick();
      checkOutput("press_latency_10", key_state[0], 32'h1);
      tick();
      checkOutput("press_pulse", key_press, 32'h1);
      tick();
      checkOutput("press_pulse_end", key_press, 32'h0);
      regRead(2'd1, 32'h1, "press_event");
      applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'h0);
      repeat (10) tick();
      checkOutput("release_state", key_state[0], 32'h0);
      tick();
      checkOutput("release_pulse", key_release, 32'h1);
      tick();
      checkOutput("release_pulse_end", key_release, 32'h0);
      regRead(2'd1, 32'h1, "release_event_kept");
      regWrite(2'd1, 32'h1);

      // Interrupt and W1C with key 1
      regWrite(2'd2, 32'h3);
      applyStimulus(4'hD, 1'b0, 1'b0, 2'd0, 32'h0);
      n = 0;
      while (irq !== 1'b1 && n < 30) begin tick(); n++; end
      checkOutput("irq_assert", irq, 32'h1);
      regWrite(2'd1, 32'h2);
      checkOutput("irq_hold_one_cycle", irq, 32'h1);
      tick();
      checkOutput("irq_clear", irq, 32'h0);
      regRead(2'd1, 32'h0, "w1c_event");
      regRead(2'd0, 32'h2, "held_state");
      applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'h0);
      repeat (15) tick();

      // Set-wins collision on key 2
      applyStimulus(4'hB, 1'b0, 1'b0, 2'd0, 32'h0);
      n = 0;
      while (key_press[2] !== 1'b1 && n < 30) begin tick(); n++; end
      checkOutput("collide_press", key_press[2], 32'h1);
      regWrite(2'd1, 32'h4);
      regRead(2'd1, 32'h4, "collide_set_wins");
      regWrite(2'd1, 32'h4);
      applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'h0);
      repeat (15) tick();

      // Reset in the middle of a count on key 3
      applyStimulus(4'h7, 1'b0, 1'b0, 2'd0, 32'h0);
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midrst_outputs", {key_state, key_press, key_release}, 32'h0);
      repeat (9) tick();
      checkOutput("midrst_latency_9", key_state[3], 32'h0);
      tick();
      checkOutput("midrst_latency_10", key_state[3], 32'h1);
      applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'h0);
      repeat (15) tick();

      // Randomised traffic checked against the model
      for (int k = 0; k < NKEY; k++) hold[k] = 0;
      rk = 4'hF;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < NKEY; k++) begin
            if (hold[k] == 0) begin
               rk[k]   = 1'($urandom_range(0, 1));
               hold[k] = $urandom_range(1, 16);
            end
            hold[k]--;
         end
         op = $urandom_range(0, 9);
         if (op < 2)
            applyStimulus(rk, 1'b1, 1'b1, 2'($urandom_range(0, 3)), $urandom);
         else if (op < 4)
            applyStimulus(rk, 1'b1, 1'b0, 2'($urandom_range(0, 3)), 32'h0);
         else
            applyStimulus(rk, 1'b0, 1'b0, 2'd0, 32'h0);
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_debounce_ctrl.md
Name: key_debounce_ctrl

Overview:
- Upstream stage of the SoC `key` input: synchronises and debounces raw mechanical push-buttons.
- Produces clean level and edge pulses for the core.
- Exposes a small register slave: stable key state, sticky W1C event flags, per-key interrupt enables.
- Drives one level interrupt toward the processor.

Parameters:
- NKEY, 4, number of key inputs (1..32).
- DB_CYCLES, 500000, clk cycles a new level must persist before acceptance (10 ms at 50 MHz); minimum 2.
- KEY_ACTIVE_LOW, 1, 1 = pressed reads as 0 on key_in (pull-up buttons).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_in  in  NKEY  raw asynchronous button pins.
- key_state  out  NKEY  debounced state, 1 = pressed (polarity normalised).
- key_press  out  NKEY  one-cycle pulse on accepted press.
- key_release  out  NKEY  one-cycle pulse on accepted release.
- reg_sel  in  1  register access strobe.
- reg_we  in  1  1 = write, 0 = read.
- reg_addr  in  2  word address.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, registered.
- irq  out  1  level interrupt.

Behaviour:
- Reset values:
  - Outputs: key_state=0, key_press=0, key_release=0, reg_rdata=0, irq=0.
  - Internal: both synchroniser stages = idle level (1 if KEY_ACTIVE_LOW, else 0); counters=0; event=0; irq_en=0.
  - Consequence: no spurious press after reset.
- Synchroniser: 2-FF per key. Sampled level is normalised to pressed=1 after stage 2.
- Debounce, per key, counter width CNT_W = clog2(DB_CYCLES):
  - If sampled == key_state, counter clears.
  - Otherwise counter increments. On the cycle the counter equals DB_CYCLES-1, key_state flips and the counter clears.
  - Any return to key_state before that point clears the counter, so bounces shorter than DB_CYCLES are discarded.
  - Latency from a pin change to key_state: 2 sync cycles + DB_CYCLES cycles.
- Edges:
  - key_press[i] = 1 for the single cycle after key_state[i] rises 0->1.
  - key_release[i] = 1 for the single cycle after key_state[i] falls 1->0.
  - Pulses are registered, never combinational.
- Event register: event[i] is set by key_press[i] and is sticky.
- Register map, word addresses:
  - 0: key_state, read-only; writes ignored.
  - 1: event, W1C; writing 1 clears that bit.
  - 2: irq_en, R/W.
  - 3: reads 0; writes ignored.
  - Unused upper bits read 0.
- Read timing: reg_sel && !reg_we captures into reg_rdata at the next edge (1-cycle latency). reg_rdata holds its value until the next read.
- Write timing: takes effect at the edge on which reg_sel && reg_we is sampled.
- Simultaneous press and W1C on the same bit: set wins, bit stays 1.
- irq: registered OR of (event & irq_en). It asserts the cycle after event or irq_en changes and deasserts the cycle after the bits are cleared.
- Mid-operation reset: every counter and flag returns to its reset value within one cycle, and no edge pulse is emitted on reset exit.
- Keys are fully independent; simultaneous transitions on several keys each generate their own pulses in the same cycle.

Decomposition:
- Shared package (key_pkg), holding:
  - register address constants KEY_ADDR_STATE=0, KEY_ADDR_EVENT=1, KEY_ADDR_IRQEN=2;
  - data width constant 32.
- Sub-module key_debounce_bit: one key covering sync, counter, stable state and edge pulses. Instantiate it NKEY times via generate.
- Top level: holds the event/irq_en registers, read mux and irq.

Test Plan (all with DB_CYCLES=8, NKEY=4, KEY_ACTIVE_LOW=1):
- Idle after reset: key_in=4'hF, rst held 3 cycles then released, run 50 cycles -> key_state=0, no key_press/key_release pulses, irq=0, read addr 1 returns 0.
- Bounce rejection: key_in[0] driven low for 5 cycles then high, repeated 4 times -> key_state[0] stays 0, no key_press.
- Clean press and release on key 0:
  - key_in[0] held low -> key_state[0]=1 exactly 10 cycles after the pin change, key_press[0] a single 1-cycle pulse, event=4'h1.
  - Pin then held high -> key_release[0] pulse, event unchanged.
- Interrupt and W1C:
  - Write irq_en=4'h3, then press key 1 -> irq=1.
  - Write 32'h2 to addr 1 -> event=0 and irq=0 one cycle later; read addr 0 returns 32'h2 while key 1 is still held.
- Set-wins collision: W1C to bit 2 issued on the same cycle key_press[2] fires -> event[2] remains 1.
- Reset mid-count: key_in[3] low for 6 cycles, then rst pulsed for 1 cycle while the pin stays low -> counter restarts; key_state[3]=1 only 10 cycles after rst deasserts, and no pulse occurs at reset exit.
